// File: rtl/digital_gates_pkg.sv
// rtl/digital_gates_pkg.sv - shared constants for the digital gates block
// Purpose: counter width default, {a,b} combo indices and the field order of
//          the 8-bit gate vector passed from digital_gates_core to the top.
// Ports:   none (package).
package digital_gates_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Index of each {a,b} pair inside combo_seen.
  localparam logic [1:0] C00 = 2'd0;
  localparam logic [1:0] C01 = 2'd1;
  localparam logic [1:0] C10 = 2'd2;
  localparam logic [1:0] C11 = 2'd3;

  // Gate vector field order (bit index of each gate).
  localparam int GATE_W = 8;
  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NOTA = 2;
  localparam int G_NOTB = 3;
  localparam int G_NAND = 4;
  localparam int G_NOR  = 5;
  localparam int G_XOR  = 6;
  localparam int G_XNOR = 7;

  // Gate vector for a=b=0, used as the registered-output reset value.
  localparam logic [GATE_W-1:0] GATES_RESET =
    GATE_W'((1 << G_NOTA) | (1 << G_NOTB) | (1 << G_NAND) |
            (1 << G_NOR)  | (1 << G_XNOR));

endpackage

// File: rtl/digital_gates_core.sv
// rtl/digital_gates_core.sv - combinational two-input gate bank
// Purpose: computes all eight Boolean functions of a and b.
// Ports:   a, b  - gate operands
//          gates - 8-bit gate vector, field order from digital_gates_pkg
module digital_gates_core
  import digital_gates_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] gates
);

  always_comb begin
    gates         = '0;
    gates[G_AND]  = a & b;
    gates[G_OR]   = a | b;
    gates[G_NOTA] = ~a;
    gates[G_NOTB] = ~b;
    gates[G_NAND] = ~(a & b);
    gates[G_NOR]  = ~(a | b);
    gates[G_XOR]  = a ^ b;
    gates[G_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/tt_um_digital_gates.sv
// rtl/tt_um_digital_gates.sv - gate bank with input-combination tracking
// Purpose: exposes the eight gate outputs of digital_gates_core and tracks
//          which {a,b} pairs have been sampled plus a saturating count of
//          sampled input changes. Defining DIGITAL_GATES_REG_OUT_EN registers
//          the gate outputs (1-cycle latency, reset to the a=b=0 values).
// Ports:   clk, rst_n (async active-low), a, b
//          and_out, or_out, not_out_a, not_out_b, nand_out, nor_out,
//          xor_out, xnor_out - gate results
//          combo_seen - sticky per-{a,b} flags, all_seen - all four seen
//          change_cnt - saturating count of sampled {a,b} changes
module tt_um_digital_gates
  import digital_gates_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             and_out,
  output logic             or_out,
  output logic             not_out_a,
  output logic             not_out_b,
  output logic             nand_out,
  output logic             nor_out,
  output logic             xor_out,
  output logic             xnor_out,
  output logic [3:0]       combo_seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] change_cnt
);

  logic [GATE_W-1:0] gates_comb;
  logic [GATE_W-1:0] gates;
  logic [1:0]        sample;
  logic [1:0]        prev_sample;
  logic              first_valid;

  digital_gates_core u_core (
    .a     (a),
    .b     (b),
    .gates (gates_comb)
  );

`ifdef DIGITAL_GATES_REG_OUT_EN
  logic [GATE_W-1:0] gates_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gates_q <= GATES_RESET;
    end else begin
      gates_q <= gates_comb;
    end
  end

  assign gates = gates_q;
`else
  assign gates = gates_comb;
`endif

  assign and_out   = gates[G_AND];
  assign or_out    = gates[G_OR];
  assign not_out_a = gates[G_NOTA];
  assign not_out_b = gates[G_NOTB];
  assign nand_out  = gates[G_NAND];
  assign nor_out   = gates[G_NOR];
  assign xor_out   = gates[G_XOR];
  assign xnor_out  = gates[G_XNOR];

  assign sample = {a, b};

  // prev_sample only means something once first_valid is set, so the first
  // edge after reset records a sample without counting it as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      combo_seen  <= 4'b0000;
      change_cnt  <= '0;
      prev_sample <= 2'b00;
      first_valid <= 1'b0;
    end else begin
      combo_seen[sample] <= 1'b1;
      prev_sample        <= sample;
      first_valid        <= 1'b1;
      if (first_valid && (sample != prev_sample) && (change_cnt != {CNT_W{1'b1}})) begin
        change_cnt <= change_cnt + CNT_W'(1);
      end
    end
  end

  assign all_seen = combo_seen[C00] & combo_seen[C01] &
                    combo_seen[C10] & combo_seen[C11];

endmodule

// File: tb/tb_tt_um_digital_gates.sv
// tb/tb_tt_um_digital_gates.sv - directed self-checking bench for tt_um_digital_gates
module tb_tt_um_digital_gates;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;

  logic       and8, or8, nota8, notb8, nand8, nor8, xor8, xnor8;
  logic [3:0] combo8;
  logic       all8;
  logic [7:0] cnt8;

  logic       and2, or2, nota2, notb2, nand2, nor2, xor2, xnor2;
  logic [3:0] combo2;
  logic       all2;
  logic [1:0] cnt2;

  int tests;
  int fails;

  tt_um_digital_gates dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .and_out    (and8),
    .or_out     (or8),
    .not_out_a  (nota8),
    .not_out_b  (notb8),
    .nand_out   (nand8),
    .nor_out    (nor8),
    .xor_out    (xor8),
    .xnor_out   (xnor8),
    .combo_seen (combo8),
    .all_seen   (all8),
    .change_cnt (cnt8)
  );

  tt_um_digital_gates #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .and_out    (and2),
    .or_out     (or2),
    .not_out_a  (nota2),
    .not_out_b  (notb2),
    .nand_out   (nand2),
    .nor_out    (nor2),
    .xor_out    (xor2),
    .xnor_out   (xnor2),
    .combo_seen (combo2),
    .all_seen   (all2),
    .change_cnt (cnt2)
  );

  // {and,or,nota,notb,nand,nor,xor,xnor}
  function automatic logic [7:0] gv8();
    return {and8, or8, nota8, notb8, nand8, nor8, xor8, xnor8};
  endfunction

  function automatic logic [7:0] gv2();
    return {and2, or2, nota2, notb2, nand2, nor2, xor2, xnor2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clock is only produced by this task, so it can be held stopped.
  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #2;
  endtask

  logic [7:0] truth [4];

  initial begin
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    rst_n = 1'b0;
    truth[0] = 8'b00111101;
    truth[1] = 8'b01101010;
    truth[2] = 8'b01011010;
    truth[3] = 8'b11000001;
    #2;

    // Reset state
    check("rst_combo8", 32'(combo8), 32'h0);
    check("rst_cnt8",   32'(cnt8),   32'h0);
    check("rst_all8",   32'(all8),   32'h0);
    check("rst_cnt2",   32'(cnt2),   32'h0);
`ifdef DIGITAL_GATES_REG_OUT_EN
    check("rst_gates",  32'(gv8()),  32'(truth[0]));
`endif

    // Truth table
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
`ifdef DIGITAL_GATES_REG_OUT_EN
      tick();
`else
      #10;
`endif
      check($sformatf("truth8_%0d", i), 32'(gv8()), 32'(truth[i]));
      check($sformatf("truth2_%0d", i), 32'(gv2()), 32'(truth[i]));
    end

    // Clocked sweep 00,01,10,11
    {a, b} = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      tick();
    end
    check("sweep_combo", 32'(combo8), 32'hf);
    check("sweep_all",   32'(all8),   32'h1);
    check("sweep_cnt",   32'(cnt8),   32'h3);

    // Hold 11 for 10 edges
    do_reset();
    {a, b} = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    check("hold_cnt",   32'(cnt8),   32'h0);
    check("hold_combo", 32'(combo8), 32'h8);
    check("hold_all",   32'(all8),   32'h0);

    // Toggle a every edge: 10 samples, 9 changes
    do_reset();
    {a, b} = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      a = ~a;
    end
    check("tog_cnt8",   32'(cnt8),   32'h9);
    check("tog_cnt2",   32'(cnt2),   32'h3);
    check("tog_combo2", 32'(combo2), 32'h5);

    // Asynchronous reset mid-sweep
    do_reset();
    {a, b} = 2'b00;
    tick();
    {a, b} = 2'b01;
    tick();
    check("mid_cnt_pre",   32'(cnt8),   32'h1);
    check("mid_combo_pre", 32'(combo8), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_combo_async", 32'(combo8), 32'h0);
    check("mid_cnt_async",   32'(cnt8),   32'h0);
    check("mid_cnt2_async",  32'(cnt2),   32'h0);
    #2;
    rst_n = 1'b1;
    #5;
    tick();
    check("mid_first_cnt",   32'(cnt8),   32'h0);
    check("mid_first_combo", 32'(combo8), 32'h2);
    {a, b} = 2'b10;
    tick();
    check("mid_second_cnt",  32'(cnt8),   32'h1);

`ifdef DIGITAL_GATES_REG_OUT_EN
    // Registered outputs: one cycle latency
    {a, b} = 2'b00;
    do_reset();
    {a, b} = 2'b11;
    #1;
    check("reg_and_before", 32'(and8), 32'h0);
    tick();
    check("reg_and_after",  32'(and8), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
